// File: rtl/cr_structs.sv
// Shared bus structures for the TLV datapath.
// tlvp_if_bus_t: one TLV stream word as written into or read from the TLV FIFOs.
package cr_structs;

  typedef struct packed {
    logic        insert;
    logic [7:0]  typen;
    logic        sot;
    logic        eot;
    logic        tlast;
    logic [7:0]  tuser;
    logic [31:0] tdata;
  } tlvp_if_bus_t;

endpackage

// File: rtl/cr_tlvp_pkg.sv
// Types and widths for the TLV parser outbound scheduler.
//   tlvp_ob_sched_state_e : scheduler grant state
//   TLVP_OB_WEIGHT_W      : width of the per-source WRR weight counters
//   TLVP_OB_WCNT_W        : width of the per-grant word counter
package cr_tlvp_pkg;

  localparam int unsigned TLVP_OB_WEIGHT_W = 4;
  localparam int unsigned TLVP_OB_WCNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_PT  = 2'd1,
    GNT_USR = 2'd2
  } tlvp_ob_sched_state_e;

endpackage

// File: rtl/cr_tlvp_ob.sv
// Outbound TLV path: the scheduler is implemented in cr_tlvp_ob_sched.sv.

// File: rtl/cr_tlvp_ob_wrr_pick.sv
// Weighted round-robin picker for the outbound scheduler.
// Keeps the RR pointer (0 = pt, 1 = usr) and one consecutive-TLV counter per source.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   pt_req       pt FIFO non-empty
//   usr_req      usr FIFO non-empty
//   eot_pop      an eot word is being popped this cycle
//   pop_usr      the current pop is from usr (else pt)
//   force_flip   runaway TLV released: point at the other side, clear counts
//   pick_usr     source to grant from IDLE (1 = usr, 0 = pt)
module cr_tlvp_ob_wrr_pick
  import cr_tlvp_pkg::*;
#(
  parameter int unsigned PT_WEIGHT  = 1,
  parameter int unsigned USR_WEIGHT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pt_req,
  input  logic usr_req,
  input  logic eot_pop,
  input  logic pop_usr,
  input  logic force_flip,
  output logic pick_usr
);

  localparam logic [TLVP_OB_WEIGHT_W-1:0] PtWt  = TLVP_OB_WEIGHT_W'(PT_WEIGHT);
  localparam logic [TLVP_OB_WEIGHT_W-1:0] UsrWt = TLVP_OB_WEIGHT_W'(USR_WEIGHT);

  logic                        ptr_q, ptr_d;
  logic [TLVP_OB_WEIGHT_W-1:0] pt_cnt_q, pt_cnt_d;
  logic [TLVP_OB_WEIGHT_W-1:0] usr_cnt_q, usr_cnt_d;
  logic [TLVP_OB_WEIGHT_W-1:0] pt_cnt_inc, usr_cnt_inc;

  // Counters saturate at their weight so a lone source never overflows them.
  assign pt_cnt_inc  = (pt_cnt_q  >= PtWt)  ? pt_cnt_q  : pt_cnt_q  + 1'b1;
  assign usr_cnt_inc = (usr_cnt_q >= UsrWt) ? usr_cnt_q : usr_cnt_q + 1'b1;

  always_comb begin
    ptr_d     = ptr_q;
    pt_cnt_d  = pt_cnt_q;
    usr_cnt_d = usr_cnt_q;
    if (force_flip) begin
      ptr_d     = ~pop_usr;
      pt_cnt_d  = '0;
      usr_cnt_d = '0;
    end else if (eot_pop) begin
      if (!pop_usr) begin
        if (pt_cnt_inc >= PtWt && usr_req) begin
          ptr_d     = 1'b1;
          pt_cnt_d  = '0;
          usr_cnt_d = '0;
        end else begin
          pt_cnt_d = pt_cnt_inc;
        end
      end else begin
        if (usr_cnt_inc >= UsrWt && pt_req) begin
          ptr_d     = 1'b0;
          pt_cnt_d  = '0;
          usr_cnt_d = '0;
        end else begin
          usr_cnt_d = usr_cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      pt_cnt_q  <= '0;
      usr_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pt_cnt_q  <= pt_cnt_d;
      usr_cnt_q <= usr_cnt_d;
    end
  end

  // Pointer only arbitrates when both sides are waiting.
  assign pick_usr = (pt_req && usr_req) ? ptr_q : usr_req;

endmodule

// File: rtl/cr_tlvp_ob_sched.sv
// Outbound scheduler: drains the pt and usr show-ahead FIFOs into one registered
// tlvp_if_bus_t write stream, granting whole TLVs with weighted round-robin and
// releasing any grant that runs MAX_TLV_WORDS pops without an eot.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   pt_ib_empty/pt_ib_tlv/pt_ib_rd     pt FIFO status, head word, pop
//   usr_ib_empty/usr_ib_tlv/usr_ib_rd  usr FIFO status, head word, pop
//   ob_afull                     downstream almost full (no pop while high)
//   ob_wen/ob_wdata              registered outbound write
//   sched_busy                   a grant is held
//   sched_error                  sticky runaway-TLV flag
// Optional (CR_TLVP_OB_SCHED_STATS_EN): pt_tlv_cnt/usr_tlv_cnt count eot pops per source.
module cr_tlvp_ob_sched
  import cr_tlvp_pkg::*;
  import cr_structs::*;
#(
  parameter int unsigned PT_WEIGHT     = 1,
  parameter int unsigned USR_WEIGHT    = 1,
  parameter int unsigned MAX_TLV_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pt_ib_empty,
  input  tlvp_if_bus_t pt_ib_tlv,
  output logic         pt_ib_rd,
  input  logic         usr_ib_empty,
  input  tlvp_if_bus_t usr_ib_tlv,
  output logic         usr_ib_rd,
  input  logic         ob_afull,
  output logic         ob_wen,
  output tlvp_if_bus_t ob_wdata,
  output logic         sched_busy,
  output logic         sched_error
`ifdef CR_TLVP_OB_SCHED_STATS_EN
  ,
  output logic [31:0]  pt_tlv_cnt,
  output logic [31:0]  usr_tlv_cnt
`endif
);

  localparam logic [TLVP_OB_WCNT_W-1:0] LastWord = TLVP_OB_WCNT_W'(MAX_TLV_WORDS - 1);

  tlvp_ob_sched_state_e        state_q, state_d;
  logic [TLVP_OB_WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                        error_q;
  logic                        pop, pop_eot, limit_hit, pick_usr;
  tlvp_if_bus_t                pop_word;

  assign pt_ib_rd  = (state_q == GNT_PT)  && !pt_ib_empty  && !ob_afull;
  assign usr_ib_rd = (state_q == GNT_USR) && !usr_ib_empty && !ob_afull;

  assign pop       = pt_ib_rd | usr_ib_rd;
  assign pop_word  = usr_ib_rd ? usr_ib_tlv : pt_ib_tlv;
  assign pop_eot   = pop && pop_word.eot;
  // Last allowed pop of a grant and still no eot: release and flag.
  assign limit_hit = pop && !pop_word.eot && (wcnt_q == LastWord);

  cr_tlvp_ob_wrr_pick #(
    .PT_WEIGHT  (PT_WEIGHT),
    .USR_WEIGHT (USR_WEIGHT)
  ) u_wrr_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .pt_req     (!pt_ib_empty),
    .usr_req    (!usr_ib_empty),
    .eot_pop    (pop_eot),
    .pop_usr    (usr_ib_rd),
    .force_flip (limit_hit),
    .pick_usr   (pick_usr)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!pt_ib_empty || !usr_ib_empty) begin
          state_d = pick_usr ? GNT_USR : GNT_PT;
        end
      end
      GNT_PT, GNT_USR: begin
        if (pop_eot || limit_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (pop_eot || limit_hit) begin
      wcnt_d = '0;
    end else if (pop) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      error_q  <= 1'b0;
      ob_wen   <= 1'b0;
      ob_wdata <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      error_q <= error_q | limit_hit;
      ob_wen  <= pop;
      if (pop) begin
        ob_wdata <= pop_word;
      end
    end
  end

  assign sched_busy  = (state_q != IDLE);
  assign sched_error = error_q;

`ifdef CR_TLVP_OB_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_tlv_cnt  <= '0;
      usr_tlv_cnt <= '0;
    end else if (pop_eot) begin
      if (usr_ib_rd) begin
        usr_tlv_cnt <= usr_tlv_cnt + 1'b1;
      end else begin
        pt_tlv_cnt <= pt_tlv_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cr_tlvp_ob_sched.sv
// Self-checking bench for cr_tlvp_ob_sched. FIFOs are modelled as queues; the
// expected outbound word stream is computed at TLV granularity before each run.
module tb_cr_tlvp_ob_sched;
  import cr_structs::*;

  localparam int unsigned PtW  = 3;
  localparam int unsigned UsrW = 1;
  localparam int unsigned MaxW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pt_ib_empty = 1'b1;
  tlvp_if_bus_t pt_ib_tlv = '0;
  logic         pt_ib_rd;
  logic         usr_ib_empty = 1'b1;
  tlvp_if_bus_t usr_ib_tlv = '0;
  logic         usr_ib_rd;
  logic         ob_afull = 1'b0;
  logic         ob_wen;
  tlvp_if_bus_t ob_wdata;
  logic         sched_busy;
  logic         sched_error;
`ifdef CR_TLVP_OB_SCHED_STATS_EN
  logic [31:0]  pt_tlv_cnt;
  logic [31:0]  usr_tlv_cnt;
`endif

  cr_tlvp_ob_sched #(
    .PT_WEIGHT     (PtW),
    .USR_WEIGHT    (UsrW),
    .MAX_TLV_WORDS (MaxW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pt_ib_empty  (pt_ib_empty),
    .pt_ib_tlv    (pt_ib_tlv),
    .pt_ib_rd     (pt_ib_rd),
    .usr_ib_empty (usr_ib_empty),
    .usr_ib_tlv   (usr_ib_tlv),
    .usr_ib_rd    (usr_ib_rd),
    .ob_afull     (ob_afull),
    .ob_wen       (ob_wen),
    .ob_wdata     (ob_wdata),
    .sched_busy   (sched_busy),
`ifdef CR_TLVP_OB_SCHED_STATS_EN
    .pt_tlv_cnt   (pt_tlv_cnt),
    .usr_tlv_cnt  (usr_tlv_cnt),
`endif
    .sched_error  (sched_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int serial = 0;

  tlvp_if_bus_t pt_q[$];
  tlvp_if_bus_t usr_q[$];
  tlvp_if_bus_t exp_q[$];
  bit           exp_err_q[$];
  bit           err_exp = 1'b0;
  int           pop_cyc[$];
  bit           pop_eot_q[$];

  // Reference arbitration state, carried across scenarios like the DUT's.
  int m_ptr = 0;
  int m_cnt[2] = '{0, 0};

  task automatic add_tlv(input int src, input int len);
    for (int i = 0; i < len; i++) begin
      tlvp_if_bus_t w;
      logic [23:0]  s;
      s         = serial[23:0];
      serial++;
      w         = '0;
      w.tdata   = {(src == 0) ? 8'hA0 : 8'hB0, s};
      w.typen   = 8'($urandom);
      w.tuser   = 8'($urandom);
      w.insert  = 1'($urandom);
      w.sot     = (i == 0);
      w.eot     = (i == len - 1);
      w.tlast   = w.eot && ($urandom_range(0, 1) == 1);
      if (src == 0) pt_q.push_back(w);
      else usr_q.push_back(w);
    end
  endtask

  // Whole-TLV scheduling of the preloaded FIFO contents.
  task automatic model_schedule();
    tlvp_if_bus_t a[$];
    tlvp_if_bus_t b[$];
    int weight[2];
    weight = '{PtW, UsrW};
    a = pt_q;
    b = usr_q;
    while (a.size() > 0 || b.size() > 0) begin
      int src;
      int n;
      bit done;
      src  = (a.size() > 0 && b.size() > 0) ? m_ptr : ((a.size() > 0) ? 0 : 1);
      n    = 0;
      done = 1'b0;
      while (!done && ((src == 0) ? a.size() : b.size()) > 0) begin
        tlvp_if_bus_t w;
        bit other_waiting;
        w = (src == 0) ? a.pop_front() : b.pop_front();
        n++;
        exp_q.push_back(w);
        exp_err_q.push_back(1'b0);
        other_waiting = (src == 0) ? (b.size() > 0) : (a.size() > 0);
        if (w.eot) begin
          if (m_cnt[src] < weight[src]) m_cnt[src]++;
          if (m_cnt[src] >= weight[src] && other_waiting) begin
            m_ptr = 1 - src;
            m_cnt = '{0, 0};
          end
          done = 1'b1;
        end else if (n == MaxW) begin
          exp_err_q[exp_err_q.size() - 1] = 1'b1;
          m_ptr = 1 - src;
          m_cnt = '{0, 0};
          done = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive at negedge, check pop legality, then check the write after posedge.
  task automatic step(input bit afull);
    bit prd, urd;
    @(negedge clk);
    pt_ib_empty  = (pt_q.size() == 0);
    pt_ib_tlv    = (pt_q.size() > 0) ? pt_q[0] : '0;
    usr_ib_empty = (usr_q.size() == 0);
    usr_ib_tlv   = (usr_q.size() > 0) ? usr_q[0] : '0;
    ob_afull     = afull;
    #1;
    prd = pt_ib_rd;
    urd = usr_ib_rd;
    checks++;
    if ((prd && urd) || (prd && pt_ib_empty) || (urd && usr_ib_empty) || ((prd || urd) && afull)) begin
      errors++;
      $display("FAIL rd_legal: pt_rd=%0b usr_rd=%0b pt_empty=%0b usr_empty=%0b afull=%0b, required no illegal pop",
               prd, urd, pt_ib_empty, usr_ib_empty, afull);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (prd && pt_q.size() > 0) begin
      pop_cyc.push_back(cyc);
      pop_eot_q.push_back(pt_q[0].eot);
      void'(pt_q.pop_front());
    end
    if (urd && usr_q.size() > 0) begin
      pop_cyc.push_back(cyc);
      pop_eot_q.push_back(usr_q[0].eot);
      void'(usr_q.pop_front());
    end
    if (ob_wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ob_word: got unexpected word %h, required no write", ob_wdata);
      end else begin
        tlvp_if_bus_t e;
        e = exp_q.pop_front();
        if (exp_err_q.pop_front()) err_exp = 1'b1;
        if (ob_wdata !== e) begin
          errors++;
          $display("FAIL ob_word: got %h required %h", ob_wdata, e);
        end
        checks++;
        if (sched_error !== err_exp) begin
          errors++;
          $display("FAIL sched_error: got %0b required %0b", sched_error, err_exp);
        end
      end
    end
  endtask

  task automatic drain(input bit rand_afull);
    int guard = 0;
    while ((exp_q.size() > 0 || pt_q.size() > 0 || usr_q.size() > 0 || sched_busy) && guard < 600) begin
      step(rand_afull ? ($urandom_range(0, 3) == 0) : 1'b0);
      guard++;
    end
    step(1'b0);
    step(1'b0);
    checks++;
    if (exp_q.size() != 0 || guard >= 600) begin
      errors++;
      $display("FAIL drain: got %0d words outstanding after %0d cycles, required 0", exp_q.size(), guard);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pt_q.delete();
    usr_q.delete();
    exp_q.delete();
    exp_err_q.delete();
    pt_ib_empty  = 1'b1;
    usr_ib_empty = 1'b1;
    ob_afull     = 1'b0;
    m_ptr   = 0;
    m_cnt   = '{0, 0};
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({ob_wen, pt_ib_rd, usr_ib_rd, sched_busy, sched_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b required 00000",
               {ob_wen, pt_ib_rd, usr_ib_rd, sched_busy, sched_error});
    end
    checks++;
    if (ob_wdata !== '0) begin
      errors++;
      $display("FAIL reset_wdata: got %h required 0", ob_wdata);
    end
    apply_reset();
    step(1'b0);
    checks++;
    if (sched_busy !== 1'b0 || ob_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0b wen=%0b required 0 0", sched_busy, ob_wen);
    end
  endtask

  task automatic test_pt_only();
    for (int t = 0; t < 3; t++) add_tlv(0, 4);
    model_schedule();
    pop_cyc.delete();
    pop_eot_q.delete();
    drain(1'b0);
    checks++;
    if (pop_cyc.size() != 12) begin
      errors++;
      $display("FAIL pt_only_pops: got %0d required 12", pop_cyc.size());
    end
    for (int i = 0; i + 1 < pop_cyc.size(); i++) begin
      int want;
      want = pop_eot_q[i] ? pop_cyc[i] + 2 : pop_cyc[i] + 1;
      checks++;
      if (pop_cyc[i + 1] != want) begin
        errors++;
        $display("FAIL pt_only_gap: pop %0d at cycle %0d required %0d", i + 1, pop_cyc[i + 1], want);
      end
    end
  endtask

  task automatic test_wrr();
    for (int t = 0; t < 8; t++) add_tlv(0, 2);
    for (int t = 0; t < 4; t++) add_tlv(1, 2);
    model_schedule();
    drain(1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int np, nu;
      np = $urandom_range(0, 5);
      nu = $urandom_range(0, 5);
      for (int t = 0; t < np; t++) add_tlv(0, $urandom_range(1, MaxW));
      for (int t = 0; t < nu; t++) add_tlv(1, $urandom_range(1, MaxW));
      model_schedule();
      drain(1'b1);
    end
  endtask

  task automatic test_afull();
    int guard = 0;
    int wens = 0;
    add_tlv(0, 4);
    add_tlv(1, 2);
    model_schedule();
    pop_cyc.delete();
    pop_eot_q.delete();
    while (pop_cyc.size() < 2 && guard < 20) begin
      step(1'b0);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      if (ob_wen) wens++;
    end
    checks++;
    if (wens > 1) begin
      errors++;
      $display("FAIL afull_wen: got %0d writes during afull required at most 1", wens);
    end
    drain(1'b0);
  endtask

  task automatic test_max_words();
    apply_reset();
    add_tlv(0, 6);
    add_tlv(1, 2);
    model_schedule();
    drain(1'b0);
    checks++;
    if (sched_error !== 1'b1) begin
      errors++;
      $display("FAIL max_words_err: got %0b required 1", sched_error);
    end
  endtask

  task automatic test_reset_mid_tlv();
    int guard = 0;
    add_tlv(0, 4);
    model_schedule();
    pop_cyc.delete();
    pop_eot_q.delete();
    while (pop_cyc.size() < 2 && guard < 20) begin
      step(1'b0);
      guard++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ob_wen, pt_ib_rd, usr_ib_rd, sched_busy, sched_error} !== 5'b0 || ob_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_tlv: got ctl=%b wdata=%h required 00000 and 0",
               {ob_wen, pt_ib_rd, usr_ib_rd, sched_busy, sched_error}, ob_wdata);
    end
    apply_reset();
    step(1'b0);
    checks++;
    if (sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%0b required 0", sched_busy);
    end
    // Both sides waiting right after reset: pt must be served first.
    add_tlv(0, 1);
    add_tlv(1, 1);
    checks++;
    if (pt_q[0].tdata[31:24] !== 8'hA0) begin
      errors++;
      $display("FAIL reset_setup: got %h required A0", pt_q[0].tdata[31:24]);
    end
    model_schedule();
    drain(1'b0);
  endtask

  initial begin
    test_reset();
    test_pt_only();
    test_wrr();
    test_afull();
    test_random();
    test_max_words();
    test_reset_mid_tlv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
